// File: rtl/hazard_pkg.sv
// hazard_pkg: tag entry type, select-width helper and forwarding constants
package hazard_pkg;
  localparam int TAG_AW = 8;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic valid;
    logic wr;
    logic [TAG_AW-1:0] dst;
    logic is_load;
  } tag_t;
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-stage operand info in, forward selects/stall/counters out
interface fwd_hazard_unit_if #(
  parameter int REG_AW  = 3,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) ();
  localparam int SELW = hazard_pkg::sel_w(DEPTH);
  logic                      id_valid;
  logic [NUM_SRC-1:0]        id_src_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_reg;
  logic                      id_dst_wr;
  logic [REG_AW-1:0]         id_dst_reg;
  logic                      id_is_load;
  logic                      flush;
  logic                      ext_stall;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall_id;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          fwd_cnt;
  modport master (
    output id_valid, id_src_valid, id_src_reg, id_dst_wr, id_dst_reg, id_is_load, flush, ext_stall,
    input  fwd_sel, stall_id, stall_cnt, fwd_cnt
  );
  modport slave (
    input  id_valid, id_src_valid, id_src_reg, id_dst_wr, id_dst_reg, id_is_load, flush, ext_stall,
    output fwd_sel, stall_id, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: shadow shift register of destination tags for the post-ID stages
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold,
  input  tag_t                          din,
  output logic [DEPTH*$bits(tag_t)-1:0] ents
);
  localparam int W = $bits(tag_t);
  tag_t q [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (!hold) begin
      q[0] <= din;
      for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
    end
  end
  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign ents[e*W +: W] = q[e];
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: per-source forwarding select, load-use stall and event counters
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_READY = 2,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_unit_if.slave  bus
);
  localparam int SELW = sel_w(DEPTH);
  localparam int W    = $bits(tag_t);
  logic [DEPTH*W-1:0] ent_flat;
  tag_t               ent [1:DEPTH];
  logic [NUM_SRC-1:0] hazard;
  logic               issue;
  logic               fwd_any;
  tag_t               nxt;
  logic [CNT_W-1:0]   stall_q;
  logic [CNT_W-1:0]   fwd_q;
  for (genvar e = 0; e < DEPTH; e++) begin : g_unpack
    assign ent[e+1] = tag_t'(ent_flat[e*W +: W]);
  end
  // Scan oldest to youngest so the smallest matching entry index wins
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_AW-1:0] src;
    logic [SELW-1:0]   sel;
    logic              ld;
    logic              hit;
    assign src = bus.id_src_reg[s*REG_AW +: REG_AW];
    always_comb begin
      sel = '0;
      ld  = 1'b0;
      hit = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (bus.id_valid && bus.id_src_valid[s] && ent[k].valid && ent[k].wr &&
            ent[k].dst == TAG_AW'(src) && !(ZERO_REG != 0 && src == '0)) begin
          sel = SELW'(k);
          ld  = ent[k].is_load;
          hit = 1'b1;
        end
      end
    end
    assign hazard[s] = hit && ld && (int'(sel) < LOAD_READY);
    assign bus.fwd_sel[s*SELW +: SELW] = hazard[s] ? SELW'(FWD_RF) : sel;
  end
  assign bus.stall_id = |hazard & ~bus.flush;
  assign issue        = bus.id_valid & ~bus.stall_id & ~bus.flush;
  assign fwd_any      = |bus.fwd_sel;
  assign nxt = '{valid: issue, wr: bus.id_dst_wr, dst: TAG_AW'(bus.id_dst_reg), is_load: bus.id_is_load};
  hazard_tag_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .hold (bus.ext_stall),
    .din  (nxt),
    .ents (ent_flat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      fwd_q   <= '0;
    end else if (!bus.ext_stall) begin
      if (bus.stall_id && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (issue && fwd_any && fwd_q != '1) fwd_q <= fwd_q + 1'b1;
    end
  end
  assign bus.stall_cnt = stall_q;
  assign bus.fwd_cnt   = fwd_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench for default config plus a deep/zero-reg/narrow-counter config
module tb_fwd_hazard_unit;
  typedef struct packed {
    logic v; logic [1:0] sv; logic [2:0] s0; logic [2:0] s1; logic wr; logic [2:0] d;
    logic ld; logic fl; logic xs; logic [2:0] e0; logic [2:0] e1; logic es;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [4:0] sb [$];
  logic [6:0] sb2 [$];
  logic [4:0] obs5, exp5;
  logic [6:0] obs7, exp7;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(3), .DEPTH(3), .NUM_SRC(2), .CNT_W(16)) bus ();
  fwd_hazard_unit #(.REG_AW(3), .DEPTH(3), .NUM_SRC(2), .LOAD_READY(2), .ZERO_REG(0), .CNT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fwd_hazard_unit_if #(.REG_AW(3), .DEPTH(4), .NUM_SRC(2), .CNT_W(2)) bus2 ();
  fwd_hazard_unit #(.REG_AW(3), .DEPTH(4), .NUM_SRC(2), .LOAD_READY(3), .ZERO_REG(1), .CNT_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  function automatic step_t mk(input int v, sv, s0, s1, wr, d, ld, fl, xs, e0, e1, es);
    return '{v[0], sv[1:0], s0[2:0], s1[2:0], wr[0], d[2:0], ld[0], fl[0], xs[0], e0[2:0], e1[2:0], es[0]};
  endfunction

  task automatic apply(input step_t st);
    bus.id_valid = st.v; bus.id_src_valid = st.sv; bus.id_src_reg = {st.s1, st.s0};
    bus.id_dst_wr = st.wr; bus.id_dst_reg = st.d; bus.id_is_load = st.ld;
    bus.flush = st.fl; bus.ext_stall = st.xs;
    sb.push_back({st.e1[1:0], st.e0[1:0], st.es});
  endtask

  task automatic apply2(input step_t st);
    bus2.id_valid = st.v; bus2.id_src_valid = st.sv; bus2.id_src_reg = {st.s1, st.s0};
    bus2.id_dst_wr = st.wr; bus2.id_dst_reg = st.d; bus2.id_is_load = st.ld;
    bus2.flush = st.fl; bus2.ext_stall = st.xs;
    sb2.push_back({st.e1, st.e0, st.es});
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_src_valid = 0; bus.id_src_reg = 0; bus.id_dst_wr = 0;
    bus.id_dst_reg = 0; bus.id_is_load = 0; bus.flush = 0; bus.ext_stall = 0;
    bus2.id_valid = 0; bus2.id_src_valid = 0; bus2.id_src_reg = 0; bus2.id_dst_wr = 0;
    bus2.id_dst_reg = 0; bus2.id_is_load = 0; bus2.flush = 0; bus2.ext_stall = 0;
  endtask

  task automatic drain(input int n);
    repeat (n) begin @(negedge clk); idle(); end
  endtask

  task automatic test_reset();
    idle();
    bus.id_valid = 1; bus.id_src_valid = 2'b11; bus.id_src_reg = {3'd2, 3'd1};
    #1;
    checks++; if (bus.fwd_sel !== 4'd0) begin errors++; $display("FAIL reset_fwd_sel: got %h expected 0", bus.fwd_sel); end
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_id); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt); end
    checks++; if (bus.fwd_cnt !== 16'd0) begin errors++; $display("FAIL reset_fwd_cnt: got %0d expected 0", bus.fwd_cnt); end
    @(negedge clk); idle(); rst_n = 1;
  endtask

  task automatic test_alu_fwd();
    step_t q [$];
    q.push_back(mk(1, 3, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 3, 3, 3, 1, 4, 0, 0, 0, 1, 1, 0));
    q.push_back(mk(1, 3, 3, 5, 1, 6, 0, 0, 0, 2, 0, 0));
    foreach (q[i]) begin
      @(negedge clk); apply(q[i]); #2;
      exp5 = sb.pop_front(); obs5 = {bus.fwd_sel, bus.stall_id};
      checks++; if (obs5 !== exp5) begin errors++; $display("FAIL alu_fwd[%0d]: got %b expected %b", i, obs5, exp5); end
    end
    @(negedge clk); idle(); #2;
    checks++; if (bus.fwd_cnt !== 16'd2) begin errors++; $display("FAIL alu_fwd_cnt: got %0d expected 2", bus.fwd_cnt); end
  endtask

  task automatic test_load_use();
    step_t q [$];
    drain(3);
    q.push_back(mk(1, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 3, 2, 1, 1, 5, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 3, 2, 1, 1, 5, 0, 0, 0, 2, 0, 0));
    foreach (q[i]) begin
      @(negedge clk); apply(q[i]); #2;
      exp5 = sb.pop_front(); obs5 = {bus.fwd_sel, bus.stall_id};
      checks++; if (obs5 !== exp5) begin errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs5, exp5); end
    end
    @(negedge clk); idle(); #2;
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected 1", bus.stall_cnt); end
    checks++; if (bus.fwd_cnt !== 16'd3) begin errors++; $display("FAIL load_use_fwd_cnt: got %0d expected 3", bus.fwd_cnt); end
  endtask

  task automatic test_youngest();
    step_t q [$];
    drain(3);
    q.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 3, 1, 1, 1, 7, 0, 0, 0, 1, 1, 0));
    q.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0));
    foreach (q[i]) begin
      @(negedge clk); apply(q[i]); #2;
      exp5 = sb.pop_front(); obs5 = {bus.fwd_sel, bus.stall_id};
      checks++; if (obs5 !== exp5) begin errors++; $display("FAIL youngest[%0d]: got %b expected %b", i, obs5, exp5); end
    end
    @(negedge clk); idle(); #2;
    checks++; if (bus.fwd_cnt !== 16'd5) begin errors++; $display("FAIL youngest_fwd_cnt: got %0d expected 5", bus.fwd_cnt); end
  endtask

  task automatic test_flush();
    step_t q [$];
    drain(3);
    q.push_back(mk(1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 4, 0, 1, 6, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 3, 4, 6, 0, 0, 0, 0, 0, 2, 0, 0));
    foreach (q[i]) begin
      @(negedge clk); apply(q[i]); #2;
      exp5 = sb.pop_front(); obs5 = {bus.fwd_sel, bus.stall_id};
      checks++; if (obs5 !== exp5) begin errors++; $display("FAIL flush[%0d]: got %b expected %b", i, obs5, exp5); end
    end
    @(negedge clk); idle(); #2;
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_stall_cnt: got %0d expected 1", bus.stall_cnt); end
    checks++; if (bus.fwd_cnt !== 16'd6) begin errors++; $display("FAIL flush_fwd_cnt: got %0d expected 6", bus.fwd_cnt); end
  endtask

  task automatic test_ext_stall();
    step_t q [$];
    drain(3);
    q.push_back(mk(1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0));
    repeat (3) q.push_back(mk(1, 1, 2, 0, 1, 3, 0, 0, 1, 0, 0, 1));
    q.push_back(mk(1, 1, 2, 0, 1, 3, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 1, 2, 0, 1, 3, 0, 0, 0, 2, 0, 0));
    foreach (q[i]) begin
      @(negedge clk); apply(q[i]); #2;
      exp5 = sb.pop_front(); obs5 = {bus.fwd_sel, bus.stall_id};
      checks++; if (obs5 !== exp5) begin errors++; $display("FAIL ext_stall[%0d]: got %b expected %b", i, obs5, exp5); end
    end
    @(negedge clk); idle(); #2;
    checks++; if (bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL ext_stall_cnt: got %0d expected 2", bus.stall_cnt); end
    checks++; if (bus.fwd_cnt !== 16'd7) begin errors++; $display("FAIL ext_fwd_cnt: got %0d expected 7", bus.fwd_cnt); end
  endtask

  task automatic test_zero_reg();
    step_t q [$];
    drain(4);
    q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    foreach (q[i]) begin
      @(negedge clk); apply2(q[i]); #2;
      exp7 = sb2.pop_front(); obs7 = {bus2.fwd_sel, bus2.stall_id};
      checks++; if (obs7 !== exp7) begin errors++; $display("FAIL zero_reg[%0d]: got %b expected %b", i, obs7, exp7); end
    end
  endtask

  task automatic test_deep_load();
    step_t q [$];
    drain(4);
    q.push_back(mk(1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0));
    repeat (2) q.push_back(mk(1, 1, 5, 0, 1, 6, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 1, 5, 0, 1, 6, 0, 0, 0, 3, 0, 0));
    foreach (q[i]) begin
      @(negedge clk); apply2(q[i]); #2;
      exp7 = sb2.pop_front(); obs7 = {bus2.fwd_sel, bus2.stall_id};
      checks++; if (obs7 !== exp7) begin errors++; $display("FAIL deep_load[%0d]: got %b expected %b", i, obs7, exp7); end
    end
    @(negedge clk); idle(); #2;
    checks++; if (bus2.stall_cnt !== 2'd2) begin errors++; $display("FAIL deep_stall_cnt: got %0d expected 2", bus2.stall_cnt); end
    checks++; if (bus2.fwd_cnt !== 2'd2) begin errors++; $display("FAIL deep_fwd_cnt: got %0d expected 2", bus2.fwd_cnt); end
  endtask

  task automatic test_saturate();
    step_t q [$];
    drain(4);
    repeat (2) begin
      q.push_back(mk(1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0));
      repeat (2) q.push_back(mk(1, 1, 5, 0, 1, 6, 0, 0, 0, 0, 0, 1));
      q.push_back(mk(1, 1, 5, 0, 1, 6, 0, 0, 0, 3, 0, 0));
    end
    foreach (q[i]) begin
      @(negedge clk); apply2(q[i]); #2;
      exp7 = sb2.pop_front(); obs7 = {bus2.fwd_sel, bus2.stall_id};
      checks++; if (obs7 !== exp7) begin errors++; $display("FAIL saturate[%0d]: got %b expected %b", i, obs7, exp7); end
    end
    @(negedge clk); idle(); #2;
    checks++; if (bus2.stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_stall_cnt: got %0d expected 3", bus2.stall_cnt); end
    checks++; if (bus2.fwd_cnt !== 2'd3) begin errors++; $display("FAIL sat_fwd_cnt: got %0d expected 3", bus2.fwd_cnt); end
  endtask

  task automatic test_reset_mid();
    step_t q [$];
    drain(3);
    q.push_back(mk(1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    foreach (q[i]) begin
      @(negedge clk); apply(q[i]); #2;
      exp5 = sb.pop_front(); obs5 = {bus.fwd_sel, bus.stall_id};
      checks++; if (obs5 !== exp5) begin errors++; $display("FAIL mid_pre[%0d]: got %b expected %b", i, obs5, exp5); end
    end
    rst_n = 0; #1;
    checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %b expected 0", bus.stall_id); end
    checks++; if (bus.fwd_sel !== 4'd0) begin errors++; $display("FAIL mid_rst_fwd_sel: got %h expected 0", bus.fwd_sel); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_stall_cnt: got %0d expected 0", bus.stall_cnt); end
    checks++; if (bus.fwd_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_fwd_cnt: got %0d expected 0", bus.fwd_cnt); end
    q.delete();
    q.push_back(mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 3, 3, 2, 0, 0, 0, 0, 0, 1, 0, 0));
    foreach (q[i]) begin
      @(negedge clk);
      if (i == 0) rst_n = 1;
      apply(q[i]); #2;
      exp5 = sb.pop_front(); obs5 = {bus.fwd_sel, bus.stall_id};
      checks++; if (obs5 !== exp5) begin errors++; $display("FAIL mid_post[%0d]: got %b expected %b", i, obs5, exp5); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_flush();
    test_ext_stall();
    test_zero_reg();
    test_deep_load();
    test_saturate();
    test_reset_mid();
    @(negedge clk); idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
